// File: rtl/biquad8_coeff_loader.sv
// ---------------------------------------------------------------------------
// biquad8_coeff_loader
// Holds a small table of {reg_adr[6:0], coeff[17:0]} entries and, on a start
// pulse, pushes the first len entries to a WISHBONE target one transfer at a
// time. It then writes 32'h1 to register 7'h00 to commit the new coefficients.
// A bus error aborts the load. The commit write is skipped on abort, and err_o
// latches.
//
// Optional build macro: BIQUAD8_LOADER_TIMEOUT_EN
//   When defined, a transfer with no ack or err for TIMEOUT cycles is handled
//   exactly like m_err_i. When undefined, the loader waits forever for a
//   response.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   tbl_wr_i/tbl_adr_i/tbl_dat_i table write port (ignored while busy_o)
//   start_i, len_i              start pulse and number of entries to load
//   busy_o, done_o, err_o       status (done_o is a 1-cycle pulse, err_o sticky)
//   m_cyc_o .. m_sel_o          WISHBONE master request (all registered)
//   m_ack_i, m_err_i            WISHBONE target response
// ---------------------------------------------------------------------------
module biquad8_coeff_loader #(
  parameter int unsigned NENTRY  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      tbl_wr_i,
  input  logic [$clog2(NENTRY)-1:0] tbl_adr_i,
  input  logic [24:0]               tbl_dat_i,
  input  logic                      start_i,
  input  logic [$clog2(NENTRY):0]   len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      m_cyc_o,
  output logic                      m_stb_o,
  output logic                      m_we_o,
  output logic [6:0]                m_adr_o,
  output logic [31:0]               m_dat_o,
  output logic [3:0]                m_sel_o,
  input  logic                      m_ack_i,
  input  logic                      m_err_i
);

  localparam int unsigned AW = $clog2(NENTRY);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = 25;

  // Elaboration-time sanity check on the configuration.
  if (NENTRY < 2 || NENTRY > 32 || (NENTRY & (NENTRY - 1)) != 0 || TIMEOUT == 0) begin : g_bad_param
    $error("biquad8_coeff_loader: NENTRY must be a power of 2 in 2..32 and TIMEOUT nonzero");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WRITE  = 3'd2,
    GAP    = 3'd3,
    UPDATE = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t          state_q, state_nxt;
  logic [LW-1:0]   idx_q, idx_nxt;
  logic [LW-1:0]   len_q, len_nxt;
  logic [LW-1:0]   len_sat_c;
  logic [TW-1:0]   rd_word_c;
  logic            busy_nxt, done_nxt, err_nxt;
  logic            act_nxt;
  logic [6:0]      adr_nxt;
  logic [31:0]     dat_nxt;
  logic [3:0]      sel_nxt;
  logic            timeout_c;
  logic            abort_c;

  // Coefficient table; contents are deliberately not reset.
  logic [TW-1:0] mem [NENTRY];

  always_ff @(posedge wb_clk_i) begin
    if (tbl_wr_i && !busy_o) begin
      mem[tbl_adr_i] <= tbl_dat_i;
    end
  end

  // Requested length clamped to the table depth.
  always_comb begin
    len_sat_c = len_i;
    if (len_i > LW'(NENTRY)) begin
      len_sat_c = LW'(NENTRY);
    end
  end

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;

  // Cleared as a request is launched, counts edges while the request is up.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
    end else if (act_nxt && !m_cyc_o) begin
      to_cnt_q <= '0;
    end else if (m_cyc_o) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th edge the request is held without a response.
  always_comb begin
    timeout_c = m_cyc_o && (to_cnt_q == CW'(TIMEOUT - 1));
  end
`else
  always_comb begin
    timeout_c = 1'b0;
  end
`endif

  always_comb begin
    abort_c = m_err_i | timeout_c;
  end

  // State register and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_sel_o <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      len_q   <= len_nxt;
      busy_o  <= busy_nxt;
      done_o  <= done_nxt;
      err_o   <= err_nxt;
      m_cyc_o <= act_nxt;
      m_stb_o <= act_nxt;
      m_we_o  <= act_nxt;
      m_adr_o <= adr_nxt;
      m_dat_o <= dat_nxt;
      m_sel_o <= sel_nxt;
    end
  end

  // Next-state and next-output logic. The bus address/data registers double
  // as the table read register: the entry is read in FETCH (or in GAP for the
  // following entry) and lands on the bus on the same edge the request is
  // raised, so the gap between transfers is a single cycle.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    len_nxt   = len_q;
    busy_nxt  = busy_o;
    done_nxt  = 1'b0;
    err_nxt   = err_o;
    act_nxt   = m_cyc_o;
    adr_nxt   = m_adr_o;
    dat_nxt   = m_dat_o;
    sel_nxt   = m_sel_o;
    rd_word_c = mem[idx_q[AW-1:0]];

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_nxt   = len_sat_c;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = (len_sat_c != '0) ? FETCH : GAP;
        end
      end

      FETCH: begin
        act_nxt   = 1'b1;
        adr_nxt   = rd_word_c[24:18];
        dat_nxt   = {14'd0, rd_word_c[17:0]};
        sel_nxt   = 4'hF;
        state_nxt = WRITE;
      end

      WRITE, UPDATE: begin
        if (abort_c) begin
          act_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = FINISH;
        end else if (m_ack_i) begin
          act_nxt = 1'b0;
          if (state_q == WRITE) begin
            idx_nxt   = idx_q + LW'(1);
            state_nxt = GAP;
          end else begin
            state_nxt = FINISH;
          end
        end
      end

      GAP: begin
        act_nxt = 1'b1;
        sel_nxt = 4'hF;
        if (idx_q < len_q) begin
          adr_nxt   = rd_word_c[24:18];
          dat_nxt   = {14'd0, rd_word_c[17:0]};
          state_nxt = WRITE;
        end else begin
          adr_nxt   = 7'h00;
          dat_nxt   = 32'h0000_0001;
          state_nxt = UPDATE;
        end
      end

      FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
module tb_biquad8_coeff_loader;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        tbl_wr_i = 1'b0;
  logic [3:0]  tbl_adr_i = '0;
  logic [24:0] tbl_dat_i = '0;
  logic        start_i = 1'b0;
  logic [4:0]  len_i = '0;
  logic        busy_o, done_o, err_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [6:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_ack_i = 1'b0;
  logic        m_err_i = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Target model controls (written only by the test sequence).
  int ack_wait = 3;
  int err_at = -1;
  bit no_ack = 1'b0;
  bit stray = 1'b0;

  // Target model observations (written only by the responder).
  int wait_cnt = 0, xfer_cnt = 0, done_cnt = 0, gap_bad = 0, stable_bad = 0;
  int low_run = 0, seg = 0, cyc_run = 0;
  logic [6:0]  hold_adr;
  logic [31:0] hold_dat;
  logic [6:0]  log_adr [64];
  logic [31:0] log_dat [64];

  always #5 wb_clk_i = ~wb_clk_i;

  biquad8_coeff_loader #(.NENTRY(16), .TIMEOUT(8)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .tbl_wr_i (tbl_wr_i),
    .tbl_adr_i(tbl_adr_i),
    .tbl_dat_i(tbl_dat_i),
    .start_i  (start_i),
    .len_i    (len_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_sel_o  (m_sel_o),
    .m_ack_i  (m_ack_i),
    .m_err_i  (m_err_i)
  );

  // WISHBONE target: responds on the ack_wait-th cycle of each request.
  always @(negedge wb_clk_i) begin
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    if (!busy_o) seg = 0;
    if (done_o) done_cnt++;
    if (wb_rst_i) begin
      wait_cnt = 0;
      low_run = 0;
      cyc_run = 0;
    end else if (m_cyc_o && m_stb_o) begin
      if (wait_cnt == 0) begin
        if (seg > 0 && low_run != 1) gap_bad++;
        hold_adr = m_adr_o;
        hold_dat = m_dat_o;
      end else if (m_adr_o !== hold_adr || m_dat_o !== hold_dat) begin
        stable_bad++;
      end
      low_run = 0;
      wait_cnt++;
      cyc_run++;
      if (!no_ack && wait_cnt == ack_wait) begin
        log_adr[xfer_cnt % 64] = m_adr_o;
        log_dat[xfer_cnt % 64] = m_dat_o;
        if (xfer_cnt == err_at) begin
          m_err_i = 1'b1;
          m_ack_i = 1'b1;
        end else begin
          m_ack_i = 1'b1;
        end
        xfer_cnt++;
        seg++;
      end
    end else begin
      wait_cnt = 0;
      cyc_run = 0;
      if (busy_o) low_run++;
      if (stray) begin
        m_ack_i = 1'b1;
        m_err_i = 1'b1;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr_tbl(input logic [3:0] a, input logic [24:0] d);
    @(negedge wb_clk_i);
    tbl_wr_i = 1'b1;
    tbl_adr_i = a;
    tbl_dat_i = d;
    @(negedge wb_clk_i);
    tbl_wr_i = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len);
    @(negedge wb_clk_i);
    start_i = 1'b1;
    len_i = len;
    @(posedge wb_clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge wb_clk_i);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge wb_clk_i);
    total_cnt++;
    if (!ok) $display("FAIL %s_timeout: busy_o still %b after %0d cycles, want 0", name, busy_o, max);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    total_cnt++;
    if ({busy_o, done_o, err_o, m_cyc_o, m_stb_o, m_we_o} !== 6'b0)
      $display("FAIL reset_status: got %b want 000000", {busy_o, done_o, err_o, m_cyc_o, m_stb_o, m_we_o});
    else pass_cnt++;
    total_cnt++;
    if ({m_adr_o, m_dat_o, m_sel_o} !== 43'h0)
      $display("FAIL reset_bus: got adr %h dat %h sel %h want all 0", m_adr_o, m_dat_o, m_sel_o);
    else pass_cnt++;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic test_basic;
    int base, d0, g0;
    wr_tbl(4'd0, {7'h04, 18'h00123});
    wr_tbl(4'd1, {7'h08, 18'h3FFFF});
    base = xfer_cnt; d0 = done_cnt; g0 = gap_bad;
    ack_wait = 3;
    do_start(5'd2);
    total_cnt++;
    if ({busy_o, m_stb_o} !== 2'b10) $display("FAIL basic_edge_n: got busy/stb %b want 10", {busy_o, m_stb_o});
    else pass_cnt++;
    @(posedge wb_clk_i);
    #1;
    total_cnt++;
    if ({m_cyc_o, m_stb_o, m_we_o, m_sel_o} !== 7'b111_1111)
      $display("FAIL basic_latency: got cyc/stb/we/sel %b want 1111111", {m_cyc_o, m_stb_o, m_we_o, m_sel_o});
    else pass_cnt++;
    total_cnt++;
    if ({m_adr_o, m_dat_o} !== {7'h04, 32'h0000_0123})
      $display("FAIL basic_first_bus: got %h/%h want 04/00000123", m_adr_o, m_dat_o);
    else pass_cnt++;
    wait_idle(100, "basic");
    total_cnt++;
    if (xfer_cnt - base !== 3) $display("FAIL basic_count: got %0d want 3", xfer_cnt - base);
    else pass_cnt++;
    total_cnt++;
    if ({log_adr[base], log_dat[base], log_adr[base+1], log_dat[base+1], log_adr[base+2], log_dat[base+2]}
        !== {7'h04, 32'h0000_0123, 7'h08, 32'h0003_FFFF, 7'h00, 32'h0000_0001})
      $display("FAIL basic_seq: got %h/%h %h/%h %h/%h want 04/00000123 08/0003ffff 00/00000001",
               log_adr[base], log_dat[base], log_adr[base+1], log_dat[base+1], log_adr[base+2], log_dat[base+2]);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1 || err_o !== 1'b0)
      $display("FAIL basic_done: got done pulses %0d err %b want 1 and 0", done_cnt - d0, err_o);
    else pass_cnt++;
    total_cnt++;
    if (gap_bad - g0 !== 0 || stable_bad !== 0)
      $display("FAIL basic_gap: got bad gaps %0d unstable %0d want 0 and 0", gap_bad - g0, stable_bad);
    else pass_cnt++;
  endtask

  task automatic test_len0;
    int base, d0;
    base = xfer_cnt; d0 = done_cnt;
    ack_wait = 2;
    do_start(5'd0);
    wait_idle(50, "len0");
    total_cnt++;
    if (xfer_cnt - base !== 1 || {log_adr[base], log_dat[base]} !== {7'h00, 32'h1})
      $display("FAIL len0_xfer: got %0d xfers first %h/%h want 1 xfer 00/00000001", xfer_cnt - base, log_adr[base], log_dat[base]);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL len0_done: got %0d want 1", done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_stray_resp;
    int base;
    stray = 1'b1;
    ack_wait = 2;
    repeat (3) @(negedge wb_clk_i);
    total_cnt++;
    if ({busy_o, err_o} !== 2'b00) $display("FAIL stray_idle: got busy/err %b want 00", {busy_o, err_o});
    else pass_cnt++;
    base = xfer_cnt;
    do_start(5'd1);
    wait_idle(50, "stray");
    stray = 1'b0;
    total_cnt++;
    if (xfer_cnt - base !== 2 || log_adr[base] !== 7'h04 || log_adr[base+1] !== 7'h00 || err_o !== 1'b0)
      $display("FAIL stray_load: got %0d xfers adr %h,%h err %b want 2 04,00 0", xfer_cnt - base, log_adr[base], log_adr[base+1], err_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int base, d0;
    base = xfer_cnt; d0 = done_cnt;
    ack_wait = 5;
    do_start(5'd2);
    repeat (3) @(negedge wb_clk_i);
    start_i = 1'b1;
    len_i = 5'd1;
    tbl_wr_i = 1'b1;
    tbl_adr_i = 4'd0;
    tbl_dat_i = {7'h7F, 18'h15555};
    @(negedge wb_clk_i);
    start_i = 1'b0;
    tbl_wr_i = 1'b0;
    wait_idle(100, "busy");
    total_cnt++;
    if (xfer_cnt - base !== 3 || log_adr[base] !== 7'h04 || log_adr[base+1] !== 7'h08 || log_adr[base+2] !== 7'h00)
      $display("FAIL busy_seq: got %0d xfers adr %h,%h,%h want 3 04,08,00", xfer_cnt - base, log_adr[base], log_adr[base+1], log_adr[base+2]);
    else pass_cnt++;
    repeat (4) @(negedge wb_clk_i);
    total_cnt++;
    if (busy_o !== 1'b0 || done_cnt - d0 !== 1)
      $display("FAIL busy_restart: got busy %b done pulses %0d want 0 and 1", busy_o, done_cnt - d0);
    else pass_cnt++;
    base = xfer_cnt;
    ack_wait = 1;
    do_start(5'd1);
    wait_idle(50, "busy_tbl");
    total_cnt++;
    if ({log_adr[base], log_dat[base]} !== {7'h04, 32'h0000_0123})
      $display("FAIL busy_table: got %h/%h want 04/00000123", log_adr[base], log_dat[base]);
    else pass_cnt++;
  endtask

  task automatic test_bus_err;
    int base, d0;
    wr_tbl(4'd2, {7'h0C, 18'h00ABC});
    wr_tbl(4'd3, {7'h10, 18'h20000});
    base = xfer_cnt; d0 = done_cnt;
    ack_wait = 2;
    err_at = xfer_cnt + 1;
    do_start(5'd4);
    wait_idle(100, "err");
    err_at = -1;
    total_cnt++;
    if (xfer_cnt - base !== 2 || log_adr[base+1] !== 7'h08)
      $display("FAIL err_count: got %0d xfers second adr %h want 2 and 08", xfer_cnt - base, log_adr[base+1]);
    else pass_cnt++;
    total_cnt++;
    if (err_o !== 1'b1 || done_cnt - d0 !== 1)
      $display("FAIL err_flag: got err %b done pulses %0d want 1 and 1", err_o, done_cnt - d0);
    else pass_cnt++;
    repeat (3) @(negedge wb_clk_i);
    total_cnt++;
    if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o);
    else pass_cnt++;
    do_start(5'd0);
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL err_clear: got %b want 0", err_o);
    else pass_cnt++;
    wait_idle(50, "err_clr");
  endtask

  task automatic test_reset_mid;
    int base, d0;
    bit seen = 1'b0;
    ack_wait = 6;
    d0 = done_cnt;
    do_start(5'd2);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge wb_clk_i);
      seen = m_stb_o;
    end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    total_cnt++;
    if ({busy_o, done_o, err_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o} !== 49'h0 || !seen)
      $display("FAIL rstmid_outputs: got busy %b stb %b adr %h dat %h sel %h (stb seen %b) want all 0",
               busy_o, m_stb_o, m_adr_o, m_dat_o, m_sel_o, seen);
    else pass_cnt++;
    wb_rst_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    total_cnt++;
    if (done_cnt - d0 !== 0) $display("FAIL rstmid_nodone: got %0d pulses want 0", done_cnt - d0);
    else pass_cnt++;
    base = xfer_cnt;
    ack_wait = 1;
    do_start(5'd2);
    wait_idle(50, "rstmid");
    total_cnt++;
    if ({log_adr[base], log_dat[base], log_adr[base+1], log_dat[base+1], log_adr[base+2], log_dat[base+2]}
        !== {7'h04, 32'h0000_0123, 7'h08, 32'h0003_FFFF, 7'h00, 32'h0000_0001} || xfer_cnt - base !== 3)
      $display("FAIL rstmid_reload: got %0d xfers %h/%h %h/%h %h/%h", xfer_cnt - base,
               log_adr[base], log_dat[base], log_adr[base+1], log_dat[base+1], log_adr[base+2], log_dat[base+2]);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int max_run = 0;
    int d0;
    no_ack = 1'b1;
    d0 = done_cnt;
    do_start(5'd1);
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
    for (int i = 0; i < 60 && busy_o; i++) begin
      @(negedge wb_clk_i);
      if (cyc_run > max_run) max_run = cyc_run;
    end
    @(negedge wb_clk_i);
    total_cnt++;
    if (max_run !== 8) $display("FAIL timeout_len: got cyc high %0d cycles want 8", max_run);
    else pass_cnt++;
    total_cnt++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || done_cnt - d0 !== 1)
      $display("FAIL timeout_err: got err %b busy %b done pulses %0d want 1 0 1", err_o, busy_o, done_cnt - d0);
    else pass_cnt++;
`else
    for (int i = 0; i < 120; i++) begin
      @(negedge wb_clk_i);
      if (cyc_run > max_run) max_run = cyc_run;
    end
    total_cnt++;
    if (max_run < 100 || m_cyc_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL hold_cyc: got cyc run %0d cyc %b busy %b want >=100 1 1", max_run, m_cyc_o, busy_o);
    else pass_cnt++;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    total_cnt++;
    if ({m_cyc_o, busy_o, err_o} !== 3'b000 || done_cnt - d0 !== 0)
      $display("FAIL hold_reset: got cyc/busy/err %b done pulses %0d want 000 0", {m_cyc_o, busy_o, err_o}, done_cnt - d0);
    else pass_cnt++;
`endif
    no_ack = 1'b0;
  endtask

  task automatic test_saturate;
    int base;
    for (int i = 0; i < 16; i++) wr_tbl(4'(i), {7'(16 + i), 18'(3 * i + 1)});
    base = xfer_cnt;
    ack_wait = 1;
    do_start(5'd31);
    wait_idle(200, "sat");
    total_cnt++;
    if (xfer_cnt - base !== 17) $display("FAIL sat_count: got %0d want 17", xfer_cnt - base);
    else pass_cnt++;
    total_cnt++;
    if ({log_adr[base], log_dat[base], log_adr[base+15], log_dat[base+15], log_adr[base+16], log_dat[base+16]}
        !== {7'h10, 32'h1, 7'h1F, 32'h2E, 7'h00, 32'h1})
      $display("FAIL sat_seq: got %h/%h %h/%h %h/%h want 10/00000001 1f/0000002e 00/00000001",
               log_adr[base], log_dat[base], log_adr[base+15], log_dat[base+15], log_adr[base+16], log_dat[base+16]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_len0;
    test_stray_resp;
    test_back_to_back;
    test_bus_err;
    test_reset_mid;
    test_timeout;
    test_saturate;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
